// File: rtl/maxpool2x2.sv
// 2x2 / stride-2 signed max-pooling stage fed by the binary conv engine's result stream.
// Horizontal pair maxima of even rows are parked in a half-row buffer and merged on odd rows.
module maxpool2x2 #(
    parameter int DW   = 32,
    parameter int MAXW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          state,
    input  logic [DW-1:0] din,
    input  logic          ivalid,
    input  logic          idone,
    output logic [DW-1:0] dout,
    output logic          ovalid,
    output logic          done
);

    localparam int CW = $clog2(MAXW);
    localparam int BN = MAXW / 2;
    localparam int BW = $clog2(BN);

    localparam logic [CW-1:0] W_L1 = CW'(MAXW);
    localparam logic [CW-1:0] W_L2 = CW'(8);

    logic [CW-1:0]        col;
    logic [CW-1:0]        row;
    logic [CW-1:0]        w_r;
    logic [CW-1:0]        w_cur;
    logic [CW-1:0]        w_last;
    logic [BW-1:0]        bidx;
    logic                 frame_start;
    logic                 last;
    logic signed [DW-1:0] sdin;
    logic signed [DW-1:0] hold;
    logic signed [DW-1:0] hmax;
    logic signed [DW-1:0] bval;
    logic signed [DW-1:0] pmax;
    logic signed [DW-1:0] row_buf [BN];

    // Width is taken from the layer select only at the first sample of a frame.
    always_comb begin
        frame_start = (col == '0) && (row == '0);
        w_cur       = frame_start ? (state ? W_L2 : W_L1) : w_r;
        w_last      = w_cur - CW'(1);
        last        = (col == w_last) && (row == w_last);
        bidx        = BW'(col >> 1);
        sdin        = $signed(din);
        bval        = row_buf[bidx];
        hmax        = (sdin > hold) ? sdin : hold;
        pmax        = (hmax > bval) ? hmax : bval;
    end

    // idone is applied after the coincident sample so that sample still counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col    <= '0;
            row    <= '0;
            w_r    <= W_L1;
            dout   <= '0;
            ovalid <= 1'b0;
            done   <= 1'b0;
        end else begin
            ovalid <= 1'b0;
            done   <= 1'b0;
            if (ivalid) begin
                if (frame_start) begin
                    w_r <= w_cur;
                end
                if (col[0] && row[0]) begin
                    dout   <= pmax;
                    ovalid <= 1'b1;
                    done   <= last;
                end
                if (col == w_last) begin
                    col <= '0;
                    row <= (row == w_last) ? '0 : row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (idone) begin
                col <= '0;
                row <= '0;
            end
        end
    end

    // Datapath storage needs no reset; its contents are always rewritten before use.
    always_ff @(posedge clk) begin
        if (ivalid) begin
            if (!col[0]) begin
                hold <= sdin;
            end else if (!row[0]) begin
                row_buf[bidx] <= hmax;
            end
        end
    end

endmodule

// File: tb/tb_maxpool2x2.sv
// Directed self-checking bench for maxpool2x2: ramps, bubbles, aborts and signed corner windows.
module tb_maxpool2x2;

    logic        clk = 1'b0;
    logic        rst;
    logic        state;
    logic [31:0] din;
    logic        ivalid;
    logic        idone;
    logic [31:0] dout;
    logic        ovalid;
    logic        done;

    int errors = 0;
    int checks = 0;

    logic [31:0] out_q[$];
    logic        done_q[$];
    int          cyc = 0;
    int          last_iv = 0;
    int          done_cyc = -1;
    logic [31:0] frame6 [64];
    logic [31:0] exp6 [16];

    maxpool2x2 #(.DW(32), .MAXW(24)) dut (
        .clk    (clk),
        .rst    (rst),
        .state  (state),
        .din    (din),
        .ivalid (ivalid),
        .idone  (idone),
        .dout   (dout),
        .ovalid (ovalid),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ivalid) last_iv <= cyc;
        cyc <= cyc + 1;
    end

    // Collects every pooled output, away from the active edge.
    always @(negedge clk) begin
        if (ovalid) begin
            out_q.push_back(dout);
            done_q.push_back(done);
        end
        if (done) done_cyc = cyc;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] value, input int gap, input logic with_done);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            ivalid = 1'b0;
            idone  = 1'b0;
        end
        @(negedge clk);
        din    = value;
        ivalid = 1'b1;
        idone  = with_done;
    endtask

    task automatic idle(input int n);
        for (int g = 0; g < n; g++) begin
            @(negedge clk);
            ivalid = 1'b0;
            idone  = 1'b0;
        end
    endtask

    function automatic logic [31:0] sampleVal(input int w, input int mode, input int r, input int c);
        int v;
        if (mode == 0) v = r * w + c;
        else if (mode == 1) v = -(r * w + c);
        else return frame6[r * 8 + c];
        return 32'(v);
    endfunction

    function automatic logic [31:0] expVal(input int w, input int mode, input int k);
        int i, j, v;
        i = k / (w / 2);
        j = k % (w / 2);
        if (mode == 0) v = (2 * i + 1) * w + 2 * j + 1;
        else if (mode == 1) v = -(2 * i * w + 2 * j);
        else return exp6[k];
        return 32'(v);
    endfunction

    // Drives a full frame; optionally inserts row gaps and random bubbles, and toggles state mid-frame.
    task automatic runFrame(input int w, input int mode, input bit bubbles, input bit toggle);
        int gap;
        for (int r = 0; r < w; r++) begin
            for (int c = 0; c < w; c++) begin
                gap = 0;
                if (bubbles) begin
                    if (c == 0 && r > 0) gap = 5;
                    else if ($urandom_range(0, 3) == 0) gap = $urandom_range(1, 3);
                end
                if (toggle && r == 1 && c == 2) state = ~state;
                applyStimulus(sampleVal(w, mode, r, c), gap, 1'b0);
            end
        end
        idle(3);
    endtask

    task automatic checkFrame(input string tag, input int w, input int mode);
        int n;
        int ndone;
        n = (w / 2) * (w / 2);
        ndone = 0;
        checkOutput({tag, "_count"}, 32'(out_q.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            if (k < out_q.size()) begin
                checkOutput($sformatf("%s_val%0d", tag, k), out_q[k], expVal(w, mode, k));
                if (done_q[k]) ndone++;
            end
        end
        if (out_q.size() == n) checkOutput({tag, "_done_last"}, {31'd0, done_q[n-1]}, 32'd1);
        checkOutput({tag, "_done_count"}, 32'(ndone), 32'd1);
        checkOutput({tag, "_done_timing"}, 32'(done_cyc), 32'(last_iv + 1));
    endtask

    task automatic clearCapture();
        out_q.delete();
        done_q.delete();
        done_cyc = -1;
    endtask

    initial begin
        rst    = 1'b1;
        state  = 1'b0;
        din    = '0;
        ivalid = 1'b0;
        idone  = 1'b0;

        // Reset state
        idle(2);
        checkOutput("reset_dout", dout, 32'd0);
        checkOutput("reset_ovalid", {31'd0, ovalid}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Test 1: layer 1 ramp, contiguous
        clearCapture();
        state = 1'b0;
        runFrame(24, 0, 1'b0, 1'b0);
        checkFrame("t1", 24, 0);

        // Test 2: layer 2 negative ramp
        clearCapture();
        state = 1'b1;
        runFrame(8, 1, 1'b0, 1'b0);
        checkFrame("t2", 8, 1);

        // Test 3: layer 1 ramp with row gaps and bubbles
        clearCapture();
        state = 1'b0;
        runFrame(24, 0, 1'b1, 1'b0);
        checkFrame("t3", 24, 0);

        // Test 4: async reset after 30 samples, then a full frame
        clearCapture();
        state = 1'b0;
        for (int s = 0; s < 30; s++) applyStimulus(sampleVal(24, 0, s / 24, s % 24), 0, 1'b0);
        @(negedge clk);
        ivalid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("t4_async_dout", dout, 32'd0);
        checkOutput("t4_async_ovalid", {31'd0, ovalid}, 32'd0);
        checkOutput("t4_pre_count", 32'(out_q.size()), 32'd3);
        if (out_q.size() == 3) begin
            checkOutput("t4_pre_val0", out_q[0], 32'd25);
            checkOutput("t4_pre_val2", out_q[2], 32'd29);
        end
        idle(2);
        rst = 1'b0;
        clearCapture();
        idle(3);
        checkOutput("t4_post_abort_count", 32'(out_q.size()), 32'd0);
        runFrame(24, 0, 1'b0, 1'b0);
        checkFrame("t4", 24, 0);

        // Test 5: idone coincident with the 50th sample of a layer 2 frame, then full frame with state toggle
        clearCapture();
        state = 1'b1;
        for (int s = 0; s < 50; s++) applyStimulus(sampleVal(8, 0, s / 8, s % 8), 0, s == 49);
        idle(3);
        checkOutput("t5_abort_count", 32'(out_q.size()), 32'd12);
        checkOutput("t5_abort_no_done", 32'(done_cyc), 32'hFFFFFFFF);
        if (out_q.size() == 12) checkOutput("t5_abort_val11", out_q[11], 32'd47);
        clearCapture();
        runFrame(8, 0, 1'b0, 1'b1);
        checkFrame("t5", 8, 0);

        // Test 6: signed extremes and all-negative window
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) frame6[r * 8 + c] = 32'(-(r * 8 + c));
        frame6[0]  = 32'h80000000; frame6[1]  = 32'h00000000;
        frame6[8]  = 32'hFFFFFFFF; frame6[9]  = 32'h7FFFFFFF;
        frame6[2]  = 32'h7FFFFFFF; frame6[3]  = 32'h80000000;
        frame6[10] = 32'hFFFFFFFF; frame6[11] = 32'h00000000;
        frame6[4]  = 32'(-5);      frame6[5]  = 32'(-3);
        frame6[12] = 32'(-9);      frame6[13] = 32'(-3);
        frame6[6]  = 32'h80000000; frame6[7]  = 32'h80000000;
        frame6[14] = 32'h80000000; frame6[15] = 32'h80000000;
        for (int k = 0; k < 16; k++) exp6[k] = 32'(-(16 * (k / 4) + 2 * (k % 4)));
        exp6[0] = 32'h7FFFFFFF;
        exp6[1] = 32'h7FFFFFFF;
        exp6[2] = 32'(-3);
        exp6[3] = 32'h80000000;
        clearCapture();
        state = 1'b1;
        runFrame(8, 2, 1'b0, 1'b0);
        checkFrame("t6", 8, 2);

        // Stray idone after a completed frame must do nothing
        clearCapture();
        @(negedge clk);
        idone = 1'b1;
        idle(3);
        checkOutput("idle_idone_no_output", 32'(out_q.size()), 32'd0);
        runFrame(8, 1, 1'b0, 1'b0);
        checkFrame("t7", 8, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
